// File: rtl/fminmax_pkg.sv
// Shared types and constants for the floating-point min/max unit.
package fminmax_pkg;

    // Operation select; bit 1 selects NaN propagation, bit 0 selects max.
    typedef enum logic [1:0] {
        OP_MINNUM  = 2'b00,
        OP_MAXNUM  = 2'b01,
        OP_MINIMUM = 2'b10,
        OP_MAXIMUM = 2'b11
    } op_e;

    // Operand classes.
    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUB,
        CLS_NORM,
        CLS_INF,
        CLS_QNAN,
        CLS_SNAN
    } cls_e;

    // Bit positions inside the 5-bit status word {NV,DZ,OF,UF,NX}.
    localparam int ST_NV = 4;
    localparam int ST_DZ = 3;
    localparam int ST_OF = 2;
    localparam int ST_UF = 1;
    localparam int ST_NX = 0;

    // Canonical quiet NaN (sign 0, exponent all ones, mantissa MSB only),
    // right-aligned in 64 bits; callers keep the low W bits.
    function automatic logic [63:0] canon_nan(int expo_w, int mant_w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (i >= mant_w - 1 && i < mant_w + expo_w) r[i] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fminmax_if.sv
// Operation/result bus of the min/max unit.
// Handshake: a transfer happens on a rising edge where valid && ready on that
// side; the producer holds its payload stable while valid && !ready.
interface fminmax_if #(
    parameter int W     = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     ina;
    logic [W-1:0]     inb;
    logic [1:0]       op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     res;
    logic [4:0]       status;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, ina, inb, op, in_tag, out_ready,
        input  in_ready, out_valid, res, status, out_tag
    );

    modport slave (
        input  in_valid, ina, inb, op, in_tag, out_ready,
        output in_ready, out_valid, res, status, out_tag
    );
endinterface

// File: rtl/fminmax_core.sv
// Combinational classify / compare / select for one min/max operation.
module fminmax_core
    import fminmax_pkg::*;
#(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23,
    localparam int W = SIGN_W + EXPO_W + MANT_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    output logic [W-1:0] res,
    output logic [4:0]   status
);

    localparam logic [63:0] CANON_FULL = canon_nan(EXPO_W, MANT_W);

    function automatic cls_e classify(logic [W-1:0] x);
        logic [EXPO_W-1:0] e;
        logic [MANT_W-1:0] m;
        e = x[MANT_W +: EXPO_W];
        m = x[MANT_W-1:0];
        if (&e) begin
            if (m == '0)          return CLS_INF;
            else if (m[MANT_W-1]) return CLS_QNAN;
            else                  return CLS_SNAN;
        end else if (e == '0) begin
            return (m == '0) ? CLS_ZERO : CLS_SUB;
        end
        return CLS_NORM;
    endfunction

    cls_e cls_a, cls_b;
    op_e  op_v;
    logic nan_a, nan_b, snan_a, snan_b;
    logic a_lt_b, take_a, is_max, propagate;

    assign op_v      = op_e'(op);
    assign cls_a     = classify(a);
    assign cls_b     = classify(b);
    assign snan_a    = (cls_a == CLS_SNAN);
    assign snan_b    = (cls_b == CLS_SNAN);
    assign nan_a     = snan_a || (cls_a == CLS_QNAN);
    assign nan_b     = snan_b || (cls_b == CLS_QNAN);
    assign is_max    = (op_v == OP_MAXNUM) || (op_v == OP_MAXIMUM);
    assign propagate = (op_v == OP_MINIMUM) || (op_v == OP_MAXIMUM);

    // Sign-magnitude order on non-NaN values; differing signs put -0 below +0.
    always_comb begin
        if (a[W-1] != b[W-1])  a_lt_b = a[W-1];
        else if (!a[W-1])      a_lt_b = (a[W-2:0] < b[W-2:0]);
        else                   a_lt_b = (a[W-2:0] > b[W-2:0]);
    end

    // min takes A when A<B, max takes A when !(A<B); equal values are identical bits.
    assign take_a = a_lt_b ^ is_max;

    // Result selection and flags; the result is always a verbatim operand or canonical NaN.
    always_comb begin
        res    = take_a ? a : b;
        status = '0;
        if (nan_a || nan_b) begin
            if (propagate || (nan_a && nan_b)) res = CANON_FULL[W-1:0];
            else if (nan_a)                    res = b;
            else                               res = a;
        end
        status[ST_NV] = snan_a || snan_b;
        // Selection never divides, overflows, underflows or rounds.
        status[ST_DZ] = 1'b0;
        status[ST_OF] = 1'b0;
        status[ST_UF] = 1'b0;
        status[ST_NX] = 1'b0;
    end

endmodule

// File: rtl/fminmax_pipe.sv
// Pipelined floating-point min/max unit with elastic valid/ready stages.
module fminmax_pipe
    import fminmax_pkg::*;
#(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4,
    localparam int W = SIGN_W + EXPO_W + MANT_W
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    fminmax_if.slave bus
);

    logic [W-1:0]     core_res;
    logic [4:0]       core_status;
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] rdy;
    logic [W-1:0]     res_q [STAGES];
    logic [4:0]       st_q  [STAGES];
    logic [TAG_W-1:0] tag_q [STAGES];
    logic             take;

    fminmax_core #(
        .SIGN_W (SIGN_W),
        .EXPO_W (EXPO_W),
        .MANT_W (MANT_W)
    ) u_core (
        .a      (bus.ina),
        .b      (bus.inb),
        .op     (bus.op),
        .res    (core_res),
        .status (core_status)
    );

    // Per-stage ready: a stage can load when empty or when its successor can.
    always_comb begin
        logic chain;
        chain = bus.out_ready;
        rdy   = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            chain  = !v[i] || chain;
            rdy[i] = chain;
        end
    end

    assign take = bus.in_valid && !flush;

    // Stage registers: stage 0 captures the core result, later stages forward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < STAGES; i++) begin
                res_q[i] <= '0;
                st_q[i]  <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                v[0] <= take;
                if (take) begin
                    res_q[0] <= core_res;
                    st_q[0]  <= core_status;
                    tag_q[0] <= bus.in_tag;
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (rdy[i]) begin
                    v[i] <= v[i-1];
                    if (v[i-1]) begin
                        res_q[i] <= res_q[i-1];
                        st_q[i]  <= st_q[i-1];
                        tag_q[i] <= tag_q[i-1];
                    end
                end
            end
            if (flush) v <= '0;
        end
    end

    // The flush cycle discards its input, so the unit always reads as ready then.
    assign bus.in_ready  = flush || rdy[0];
    assign bus.out_valid = v[STAGES-1];
    assign bus.res       = res_q[STAGES-1];
    assign bus.status    = st_q[STAGES-1];
    assign bus.out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_fminmax_pipe.sv
// Self-checking bench: FP32/2-stage and FP16/4-stage instances of fminmax_pipe.
module tb_fminmax_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush32 = 1'b0;
    logic flush16 = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    fminmax_if #(.W(32), .TAG_W(4)) b32 ();
    fminmax_if #(.W(16), .TAG_W(4)) b16 ();

    fminmax_pipe #(.EXPO_W(8), .MANT_W(23), .STAGES(2), .TAG_W(4)) u32 (
        .clk (clk), .rst (rst), .flush (flush32), .bus (b32)
    );
    fminmax_pipe #(.EXPO_W(5), .MANT_W(10), .STAGES(4), .TAG_W(4)) u16 (
        .clk (clk), .rst (rst), .flush (flush16), .bus (b16)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned fld(logic [31:0] x, int lsb, int w);
        return (x >> lsb) & ((32'd1 << w) - 1);
    endfunction

    function automatic bit fp_nan(logic [31:0] x, int ew, int mw);
        return fld(x, mw, ew) == ((32'd1 << ew) - 1) && fld(x, 0, mw) != 0;
    endfunction

    function automatic bit fp_snan(logic [31:0] x, int ew, int mw);
        return fp_nan(x, ew, mw) && fld(x, mw - 1, 1) == 0;
    endfunction

    // Integer key ordering all non-NaN values; -0 maps to -1, +0 to 0.
    function automatic longint fp_key(logic [31:0] x, int ew, int mw);
        longint mag;
        mag = longint'(fld(x, 0, ew + mw));
        return (fld(x, ew + mw, 1) != 0) ? (-mag - 1) : mag;
    endfunction

    // Returns {status[4:0], res[31:0]}.
    function automatic logic [36:0] model(logic [31:0] a, logic [31:0] b, logic [1:0] op,
                                          int ew, int mw);
        bit na, nb, nv;
        logic [31:0] cn, r;
        longint ka, kb;
        na = fp_nan(a, ew, mw);
        nb = fp_nan(b, ew, mw);
        nv = fp_snan(a, ew, mw) || fp_snan(b, ew, mw);
        cn = (((32'd1 << ew) - 1) << mw) | (32'd1 << (mw - 1));
        ka = fp_key(a, ew, mw);
        kb = fp_key(b, ew, mw);
        if (na || nb) begin
            if (op[1] || (na && nb)) r = cn;
            else r = na ? b : a;
        end else if (op[0]) begin
            r = (ka >= kb) ? a : b;
        end else begin
            r = (ka <= kb) ? a : b;
        end
        return {nv, 4'b0000, r};
    endfunction

    // ---------------- scoreboards ----------------
    logic [40:0] exp_q32[$];
    logic [24:0] exp_q16[$];
    bit          hold32 = 0, hold16 = 0;
    logic [40:0] held32;
    logic [24:0] held16;

    always @(negedge clk) begin
        logic [36:0] m;
        if (rst || flush32) begin
            exp_q32.delete();
            hold32 = 0;
        end else begin
            if (hold32)
                check("stable32", {b32.out_valid, b32.out_tag, b32.status, b32.res}, {1'b1, held32});
            hold32 = 0;
            if (b32.out_valid && b32.out_ready) begin
                if (exp_q32.size() == 0) check("emit32_unexpected", 64'd1, 64'd0);
                else check("emit32", {b32.out_tag, b32.status, b32.res}, exp_q32.pop_front());
            end else if (b32.out_valid) begin
                hold32 = 1;
                held32 = {b32.out_tag, b32.status, b32.res};
            end
            if (b32.in_valid && b32.in_ready) begin
                m = model(b32.ina, b32.inb, b32.op, 8, 23);
                exp_q32.push_back({b32.in_tag, m[36:32], m[31:0]});
            end
        end
    end

    always @(negedge clk) begin
        logic [36:0] m;
        if (rst || flush16) begin
            exp_q16.delete();
            hold16 = 0;
        end else begin
            if (hold16)
                check("stable16", {b16.out_valid, b16.out_tag, b16.status, b16.res}, {1'b1, held16});
            hold16 = 0;
            if (b16.out_valid && b16.out_ready) begin
                if (exp_q16.size() == 0) check("emit16_unexpected", 64'd1, 64'd0);
                else check("emit16", {b16.out_tag, b16.status, b16.res}, exp_q16.pop_front());
            end else if (b16.out_valid) begin
                hold16 = 1;
                held16 = {b16.out_tag, b16.status, b16.res};
            end
            if (b16.in_valid && b16.in_ready) begin
                m = model({16'h0, b16.ina}, {16'h0, b16.inb}, b16.op, 5, 10);
                exp_q16.push_back({b16.in_tag, m[36:32], m[15:0]});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 11))
            0: return 32'h00000000;
            1: return 32'h80000000;
            2: return 32'h7F800000;
            3: return 32'hFF800000;
            4: return 32'h7FC00000;
            5: return 32'h7F800001;
            6: return 32'hFFA00000;
            7: return 32'h00000001;
            8: return 32'h80000001;
            9: return 32'h3F800000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 11))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'h7C00;
            3: return 16'hFC00;
            4: return 16'h7E00;
            5: return 16'h7C01;
            6: return 16'hFD00;
            7: return 16'h0001;
            8: return 16'h8001;
            9: return 16'hC000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic drain32();
        int w = 0;
        b32.in_valid  = 1'b0;
        b32.out_ready = 1'b1;
        do begin @(negedge clk); w++; end while ((exp_q32.size() != 0 || b32.out_valid) && w < 40);
        check("drain32", 64'(exp_q32.size()), 64'd0);
    endtask

    task automatic drain16();
        int w = 0;
        b16.in_valid  = 1'b0;
        b16.out_ready = 1'b1;
        do begin @(negedge clk); w++; end while ((exp_q16.size() != 0 || b16.out_valid) && w < 40);
        check("drain16", 64'(exp_q16.size()), 64'd0);
    endtask

    // One FP32 op with latency and value check against table expectations.
    task automatic run_one32(logic [31:0] a, logic [31:0] b, logic [1:0] op, logic [3:0] tag,
                             logic [31:0] eres, logic [4:0] est);
        int w = 0;
        @(posedge clk); #1;
        b32.in_valid = 1'b1; b32.ina = a; b32.inb = b; b32.op = op; b32.in_tag = tag;
        b32.out_ready = 1'b1;
        do begin @(negedge clk); w++; end while (!b32.in_ready && w < 20);
        check("accept32", 64'(b32.in_ready), 64'd1);
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        @(negedge clk);
        check("lat32_early", 64'(b32.out_valid), 64'd0);
        @(negedge clk);
        check("lat32_valid", 64'(b32.out_valid), 64'd1);
        check("vec32_res", 64'(b32.res), 64'(eres));
        check("vec32_status", 64'(b32.status), 64'(est));
        check("vec32_tag", 64'(b32.out_tag), 64'(tag));
    endtask

    task automatic rand32(int n);
        int acc_n = 0, cyc = 0;
        bit acc;
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        while (acc_n < n && cyc < n * 20) begin
            if (!b32.in_valid && $urandom_range(0, 3) != 0) begin
                b32.in_valid = 1'b1;
                b32.ina = pick32(); b32.inb = pick32();
                b32.op = 2'($urandom_range(0, 3)); b32.in_tag = 4'($urandom_range(0, 15));
            end
            b32.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = b32.in_valid && b32.in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin acc_n++; b32.in_valid = 1'b0; end
        end
        check("rand32_count", 64'(acc_n), 64'(n));
        drain32();
    endtask

    task automatic rand16(int n);
        int acc_n = 0, cyc = 0;
        bit acc;
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
        while (acc_n < n && cyc < n * 20) begin
            if (!b16.in_valid && $urandom_range(0, 3) != 0) begin
                b16.in_valid = 1'b1;
                b16.ina = pick16(); b16.inb = pick16();
                b16.op = 2'($urandom_range(0, 3)); b16.in_tag = 4'($urandom_range(0, 15));
            end
            b16.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = b16.in_valid && b16.in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin acc_n++; b16.in_valid = 1'b0; end
        end
        check("rand16_count", 64'(acc_n), 64'(n));
        drain16();
    endtask

    // ---------------- main sequence ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] res;
        logic [4:0]  st;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int t, cyc, w;
        bit acc;

        tbl[0]  = '{32'h3F800000, 32'h40000000, 2'b00, 32'h3F800000, 5'b00000};
        tbl[1]  = '{32'h3F800000, 32'h40000000, 2'b01, 32'h40000000, 5'b00000};
        tbl[2]  = '{32'h80000000, 32'h00000000, 2'b00, 32'h80000000, 5'b00000};
        tbl[3]  = '{32'h80000000, 32'h00000000, 2'b01, 32'h00000000, 5'b00000};
        tbl[4]  = '{32'h7FC00000, 32'h3F800000, 2'b00, 32'h3F800000, 5'b00000};
        tbl[5]  = '{32'h7FC00000, 32'h3F800000, 2'b10, 32'h7FC00000, 5'b00000};
        tbl[6]  = '{32'h7F800001, 32'h3F800000, 2'b00, 32'h3F800000, 5'b10000};
        tbl[7]  = '{32'h7F800001, 32'h3F800000, 2'b11, 32'h7FC00000, 5'b10000};
        tbl[8]  = '{32'h7FC00001, 32'hFFC00000, 2'b01, 32'h7FC00000, 5'b00000};
        tbl[9]  = '{32'hBF800000, 32'h7F800000, 2'b10, 32'hBF800000, 5'b00000};
        tbl[10] = '{32'hFF800000, 32'h00000001, 2'b11, 32'h00000001, 5'b00000};
        tbl[11] = '{32'hBF800000, 32'hC0000000, 2'b01, 32'hBF800000, 5'b00000};
        tbl[12] = '{32'hFF800001, 32'h7FC00000, 2'b00, 32'h7FC00000, 5'b10000};
        tbl[13] = '{32'h00000002, 32'h00000001, 2'b10, 32'h00000001, 5'b00000};

        b32.in_valid = 1'b0; b32.ina = '0; b32.inb = '0; b32.op = '0; b32.in_tag = '0;
        b32.out_ready = 1'b1;
        b16.in_valid = 1'b0; b16.ina = '0; b16.inb = '0; b16.op = '0; b16.in_tag = '0;
        b16.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid32", 64'(b32.out_valid), 64'd0);
        check("rst_payload32", {b32.out_tag, b32.status, b32.res}, 64'd0);
        check("rst_out_valid16", 64'(b16.out_valid), 64'd0);
        check("rst_payload16", {b16.out_tag, b16.status, b16.res}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready32", 64'(b32.in_ready), 64'd1);
        check("idle_in_ready16", 64'(b16.in_ready), 64'd1);

        // Table-driven single operations
        for (int i = 0; i < 14; i++) begin
            check("table_vs_model", 64'(model(tbl[i].a, tbl[i].b, tbl[i].op, 8, 23)),
                  64'({tbl[i].st, tbl[i].res}));
            run_one32(tbl[i].a, tbl[i].b, tbl[i].op, 4'(i), tbl[i].res, tbl[i].st);
        end
        drain32();

        // Backpressure: 8 ops, consumer stalled for 5 cycles
        @(posedge clk); #1;
        b32.out_ready = 1'b0;
        t = 0; cyc = 0;
        b32.in_valid = 1'b1; b32.ina = pick32(); b32.inb = pick32(); b32.op = 2'b01; b32.in_tag = 4'd0;
        while (t < 8 && cyc < 200) begin
            @(negedge clk);
            if (cyc == 2) begin
                check("full_in_ready", 64'(b32.in_ready), 64'd0);
                check("full_out_valid", 64'(b32.out_valid), 64'd1);
            end
            if (cyc == 5) check("full_pass_in_ready", 64'(b32.in_ready), 64'd1);
            acc = b32.in_valid && b32.in_ready;
            @(posedge clk); #1;
            cyc++;
            if (cyc == 5) b32.out_ready = 1'b1;
            if (acc) begin
                t++;
                if (t < 8) begin
                    b32.ina = pick32(); b32.inb = pick32();
                    b32.op = 2'($urandom_range(0, 3)); b32.in_tag = 4'(t);
                end else begin
                    b32.in_valid = 1'b0;
                end
            end
        end
        check("stream8_accepted", 64'(t), 64'd8);
        drain32();

        // Asynchronous reset while two results are held
        @(posedge clk); #1;
        b32.out_ready = 1'b0;
        b32.in_valid = 1'b1; b32.ina = 32'h3F800000; b32.inb = 32'h40000000; b32.op = 2'b01;
        b32.in_tag = 4'd9;
        repeat (2) begin @(posedge clk); #1; end
        b32.in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_held", 64'(b32.out_valid), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 64'(b32.out_valid), 64'd0);
        check("rst_mid_payload", {b32.out_tag, b32.status, b32.res}, 64'd0);
        check("rst_mid_in_ready", 64'(b32.in_ready), 64'd1);
        @(negedge clk);
        check("rst_hold_valid", 64'(b32.out_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_one32(32'hC0000000, 32'h3F800000, 2'b00, 4'd3, 32'hC0000000, 5'b00000);
        drain32();

        // FP16, 4 stages: latency of 3 after accept
        @(posedge clk); #1;
        b16.in_valid = 1'b1; b16.ina = 16'h3C00; b16.inb = 16'hC000; b16.op = 2'b00; b16.in_tag = 4'd5;
        b16.out_ready = 1'b1;
        w = 0;
        do begin @(negedge clk); w++; end while (!b16.in_ready && w < 20);
        check("accept16", 64'(b16.in_ready), 64'd1);
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("lat16_early", 64'(b16.out_valid), 64'd0);
        end
        @(negedge clk);
        check("lat16_valid", 64'(b16.out_valid), 64'd1);
        check("vec16_res", 64'(b16.res), 64'h0000C000);
        check("vec16_status", 64'(b16.status), 64'd0);
        drain16();

        // FP16 flush with three held, input offered in the flush cycle
        @(posedge clk); #1;
        b16.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            b16.in_valid = 1'b1; b16.ina = pick16(); b16.inb = pick16();
            b16.op = 2'($urandom_range(0, 3)); b16.in_tag = 4'(k);
            @(negedge clk);
            check("fill16_in_ready", 64'(b16.in_ready), 64'd1);
            @(posedge clk); #1;
        end
        flush16 = 1'b1;
        b16.ina = 16'h3C00; b16.inb = 16'h3C00; b16.in_tag = 4'd15;
        @(negedge clk);
        check("flush_in_ready", 64'(b16.in_ready), 64'd1);
        @(posedge clk); #1;
        flush16 = 1'b0;
        b16.in_valid = 1'b0;
        b16.out_ready = 1'b1;
        @(negedge clk);
        check("flush_clears", 64'(b16.out_valid), 64'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("flush_discard", 64'(b16.out_valid), 64'd0);
        end

        // Randomized traffic against the reference model
        rand32(300);
        rand16(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fminmax_pipe.md
# fminmax_pipe

Parametrised, pipelined floating-point min/max unit with valid/ready handshakes on both sides. It supports four ops: minNum/maxNum (quiet-NaN-suppressing) and IEEE 754-2019 minimum/maximum (NaN-propagating). It is configurable in format width and pipeline depth, and carries a user tag. It sits in the FP execution cluster beside the existing min unit and replaces it for all formats.

## Interface
- SIGN_W, 1, sign field width (fixed at 1)
- EXPO_W, 8, exponent field width
- MANT_W, 23, stored mantissa width
- STAGES, 2, number of register stages (legal 1..4)
- TAG_W, 4, width of the opaque tag carried with each operation
- W = SIGN_W+EXPO_W+MANT_W (localparam)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; clears all stage valids
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept this cycle
- ina  in  W  operand A
- inb  in  W  operand B
- op  in  2  00 minNum, 01 maxNum, 10 minimum, 11 maximum
- in_tag  in  TAG_W  returned unchanged with the result
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- res  out  W  result
- status  out  5  {NV,DZ,OF,UF,NX}
- out_tag  out  TAG_W  tag of this result

## Operation
- Operand classes: zero, subnormal, normal, inf, qNaN (exp all ones, mant MSB 1), sNaN (exp all ones, mant≠0, MSB 0).
- Ordering: sign-magnitude total order on non-NaN values; -0 < +0.
- minNum/maxNum:
  - One operand NaN: return the other operand.
  - Both NaN: return canonical NaN.
- minimum/maximum: any NaN operand returns canonical NaN.
- Canonical NaN: sign 0, exponent all ones, mantissa MSB 1, rest 0 (FP32: 0x7FC00000).
- Status flags:
  - NV=1 iff either operand is an sNaN, in all ops.
  - DZ, OF, UF and NX are always 0.
- The result is a bit-exact copy of the selected operand (no requantisation).
- Classification, compare and selection are computed combinationally from the inputs and captured into stage 0 on accept.
- Stages 1..STAGES-1 forward {valid, res, status, tag}.

## Timing
- Accept: in_valid && in_ready at a rising edge.
- Emit: out_valid && out_ready at a rising edge.
- Latency: a result accepted at edge N is presented with out_valid=1 after edge N+STAGES-1, with no stall.
- Throughput: one operation per cycle when out_ready is held high.
- Per-stage ready:
  - ready[i] = !v[i] || ready[i+1]
  - ready[STAGES] = out_ready
  - in_ready = ready[0] (combinational chain; no bubbles inserted)
- A stalled stage holds its payload stable.
- out_valid, once asserted, stays asserted with res, status and out_tag unchanged until emitted.
- Order is preserved; no drops or duplicates.
- Pipeline full with out_ready=0: in_ready=0. With exactly STAGES items held, the next offer waits.
- Simultaneous emit and accept when full: both happen in the same cycle.
- flush:
  - Clears all v[i] at the edge.
  - Input presented in the flush cycle is discarded.
  - in_ready reads 1 during flush.
- Reset (async assert, any time, including mid-stall) clears:
  - all v[i]; out_valid=0
  - res=0, status=0, out_tag=0
  - in_ready reads 1 while rst=0 and the pipe is empty.
- Reset values are held while rst=1.

## Structure
- fminmax_pkg holds:
  - the op enum (OP_MINNUM, OP_MAXNUM, OP_MINIMUM, OP_MAXIMUM)
  - status bit indices (ST_NV=4, ST_DZ=3, ST_OF=2, ST_UF=1, ST_NX=0)
  - a class enum
  - a function returning the canonical NaN for given EXPO_W/MANT_W
- Sub-module fminmax_core: purely combinational classify/compare/select producing {res, status}.
- The pipeline registers and handshake live in fminmax_pipe.

## Test plan
All cases use FP32 and STAGES=2 unless stated.
- op=00, A=0x3F800000, B=0x40000000: res=0x3F800000, status=0, out_valid exactly 1 cycle after accept. With op=01: res=0x40000000.
- A=0x80000000, B=0x00000000: op=00 gives 0x80000000; op=01 gives 0x00000000; status=0.
- A=0x7FC00000, B=0x3F800000:
  - op=00 gives 0x3F800000, status=0.
  - op=10 gives 0x7FC00000.
  - A=0x7F800001 with op=00 gives 0x3F800000, status=5'b10000.
  - A=0x7F800001 with op=11 gives 0x7FC00000, status=5'b10000.
- Backpressure: stream 8 ops with tags 0..7, out_ready=0 for 5 cycles then 1. Required: in_ready drops after 2 items held, all 8 results emerge in tag order, payloads stable while stalled.
- Assert rst mid-stream with 2 valids held: out_valid=0 and res/status/out_tag=0 immediately. After release, the first new op emerges with correct latency.
- STAGES=4 and FP16 (EXPO_W=5, MANT_W=10), A=0x3C00, B=0xC000, op=00: res=0xC000 after 3-cycle latency. flush with 3 held: out_valid=0 next cycle.
